// File: rtl/dtw_pkg.sv
// Shared types, register bit positions and status helpers for the DTW core sequencer.
package dtw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_Q   = 3'd1,
        ST_SWEEP    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_DONE     = 3'd4
    } dtw_state_e;

    localparam int CR_START    = 0;
    localparam int CR_SRST     = 1;

    localparam int SR_BUSY     = 0;
    localparam int SR_DONE     = 1;
    localparam int SR_LENERR   = 2;
    localparam int SR_QCNT_LSB = 16;

    localparam int QCNT_W      = 16;
    localparam int DEF_REF_LEN = 29898;

    function automatic logic [31:0] pack_sr(input logic busy, input logic done,
                                            input logic len_err,
                                            input logic [QCNT_W-1:0] qcnt);
        logic [31:0] sr;
        sr                           = 32'd0;
        sr[SR_BUSY]                  = busy;
        sr[SR_DONE]                  = done;
        sr[SR_LENERR]                = len_err;
        sr[SR_QCNT_LSB +: QCNT_W]    = qcnt;
        return sr;
    endfunction

    function automatic logic [QCNT_W-1:0] qcnt_inc(input logic [QCNT_W-1:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/dtw_core_seq_if.sv
// Query sample stream (AXI-Stream style) between the sample source and the sequencer.
interface dtw_core_seq_if #(
    parameter int QUERY_W = 16
);
    logic [QUERY_W-1:0] s_query_tdata;
    logic               s_query_tvalid;
    logic               s_query_tready;
    logic               s_query_tlast;

    modport master (
        output s_query_tdata,
        output s_query_tvalid,
        output s_query_tlast,
        input  s_query_tready
    );

    modport slave (
        input  s_query_tdata,
        input  s_query_tvalid,
        input  s_query_tlast,
        output s_query_tready
    );
endinterface

// File: rtl/dtw_sweep_ctr.sv
// Column counter for one reference sweep plus the stage-1 registers that align
// PE valid/first/last/last_row with the 1-cycle reference RAM read latency.
module dtw_sweep_ctr #(
    parameter int REF_ADDR_W = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  abort_i,
    input  logic                  row_start_i,
    input  logic                  sweep_i,
    input  logic                  last_row_i,
    input  logic [REF_ADDR_W:0]   len_i,
    output logic                  ref_en_o,
    output logic [REF_ADDR_W-1:0] ref_addr_o,
    output logic                  row_end_o,
    output logic                  pe_valid_o,
    output logic                  pe_first_col_o,
    output logic                  pe_last_col_o,
    output logic                  pe_last_row_o
);

    localparam logic [REF_ADDR_W:0] COL_ZERO = {(REF_ADDR_W+1){1'b0}};
    localparam logic [REF_ADDR_W:0] COL_ONE  = {{REF_ADDR_W{1'b0}}, 1'b1};

    // One extra bit so a full 2^REF_ADDR_W row never wraps before its last column.
    logic [REF_ADDR_W:0] col_q, col_d;
    logic                at_first_s, at_last_s;
    logic                valid_q, valid_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                last_row_q, last_row_d;

    assign at_first_s = (col_q == COL_ZERO);
    assign at_last_s  = (col_q == (len_i - COL_ONE));

    // Next column and stage-1 flags; an abort kills the beat already in flight.
    always_comb begin
        col_d      = col_q;
        valid_d    = 1'b0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        last_row_d = 1'b0;
        if (abort_i || row_start_i) begin
            col_d = COL_ZERO;
        end else if (sweep_i) begin
            col_d = col_q + COL_ONE;
        end else begin
            col_d = col_q;
        end
        if (sweep_i && !abort_i) begin
            valid_d    = 1'b1;
            first_d    = at_first_s;
            last_d     = at_last_s;
            last_row_d = last_row_i;
        end else begin
            valid_d    = 1'b0;
        end
    end

    // Counter and stage-1 state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q      <= COL_ZERO;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            last_row_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            last_row_q <= last_row_d;
        end
    end

    assign ref_en_o       = sweep_i;
    assign ref_addr_o     = col_q[REF_ADDR_W-1:0];
    assign row_end_o      = sweep_i && at_last_s;
    assign pe_valid_o     = valid_q;
    assign pe_first_col_o = first_q;
    assign pe_last_col_o  = last_q;
    assign pe_last_row_o  = last_row_q;

endmodule

// File: rtl/dtw_core_seq.sv
// DTW core sequencer: decodes control, accepts query samples, sweeps the reference
// memory once per sample, captures the PE result and reports status.
module dtw_core_seq
    import dtw_pkg::*;
#(
    parameter int QUERY_W    = 16,
    parameter int REF_ADDR_W = 15,
    parameter int SCORE_W    = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [31:0]           dtw_cr,
    input  logic [31:0]           dtw_ref_len,
    output logic [31:0]           dtw_sr,
    dtw_core_seq_if.slave         s_query,
    output logic                  ref_en,
    output logic [REF_ADDR_W-1:0] ref_addr,
    input  logic [QUERY_W-1:0]    ref_data,
    output logic                  pe_valid,
    output logic [QUERY_W-1:0]    pe_query,
    output logic [QUERY_W-1:0]    pe_ref,
    output logic                  pe_first_col,
    output logic                  pe_last_col,
    output logic                  pe_last_row,
    input  logic                  pe_res_valid,
    input  logic [SCORE_W-1:0]    pe_res_score,
    input  logic [REF_ADDR_W-1:0] pe_res_pos,
    output logic [SCORE_W-1:0]    dtw_score,
    output logic [REF_ADDR_W-1:0] dtw_pos
);

    localparam logic [31:0] MAX_LEN = 32'd1 << REF_ADDR_W;

    dtw_state_e            state_q, state_d;
    logic                  start_prev_q;
    logic [REF_ADDR_W:0]   len_q, len_d;
    logic [QUERY_W-1:0]    qdata_q, qdata_d;
    logic                  qlast_q, qlast_d;
    logic [QCNT_W-1:0]     qcnt_q, qcnt_d;
    logic                  done_q, done_d;
    logic                  lenerr_q, lenerr_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [REF_ADDR_W-1:0] pos_q, pos_d;
    logic [31:0]           sr_q, sr_d;

    logic start_edge_s, srst_s, bad_len_s, busy_s;
    logic tready_s, handshake_s, row_start_s, sweep_s, row_end_s;
    logic cr_unused_s;

    assign cr_unused_s  = ^dtw_cr[31:2];
    assign start_edge_s = dtw_cr[CR_START] && !start_prev_q;
    assign srst_s       = dtw_cr[CR_SRST];
    assign bad_len_s    = (dtw_ref_len == 32'd0) || (dtw_ref_len > MAX_LEN);
    assign busy_s       = (state_q == ST_WAIT_Q) || (state_q == ST_SWEEP) ||
                          (state_q == ST_WAIT_RES);
    assign sweep_s      = (state_q == ST_SWEEP);
    assign tready_s     = (state_q == ST_WAIT_Q) && !srst_s;
    assign handshake_s  = tready_s && s_query.s_query_tvalid;

    // FSM next state, flag/counter updates and status word; soft reset wins over everything.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        qdata_d     = qdata_q;
        qlast_d     = qlast_q;
        qcnt_d      = qcnt_q;
        done_d      = done_q;
        lenerr_d    = lenerr_q;
        score_d     = score_q;
        pos_d       = pos_q;
        row_start_s = 1'b0;
        sr_d        = pack_sr(busy_s, done_q, lenerr_q, qcnt_q);
        if (srst_s) begin
            state_d  = ST_IDLE;
            len_d    = {(REF_ADDR_W+1){1'b0}};
            qdata_d  = {QUERY_W{1'b0}};
            qlast_d  = 1'b0;
            qcnt_d   = 16'd0;
            done_d   = 1'b0;
            lenerr_d = 1'b0;
            score_d  = {SCORE_W{1'b0}};
            pos_d    = {REF_ADDR_W{1'b0}};
            sr_d     = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_edge_s) begin
                        done_d   = 1'b0;
                        lenerr_d = 1'b0;
                        qcnt_d   = 16'd0;
                        score_d  = {SCORE_W{1'b0}};
                        pos_d    = {REF_ADDR_W{1'b0}};
                        len_d    = dtw_ref_len[REF_ADDR_W:0];
                        if (bad_len_s) begin
                            lenerr_d = 1'b1;
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_WAIT_Q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT_Q: begin
                    if (handshake_s) begin
                        qdata_d     = s_query.s_query_tdata;
                        qlast_d     = s_query.s_query_tlast;
                        qcnt_d      = qcnt_inc(qcnt_q);
                        row_start_s = 1'b1;
                        state_d     = ST_SWEEP;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_SWEEP: begin
                    if (row_end_s) begin
                        state_d = qlast_q ? ST_WAIT_RES : ST_WAIT_Q;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT_RES: begin
                    if (pe_res_valid) begin
                        score_d = pe_res_score;
                        pos_d   = pe_res_pos;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and status registers; the start history resets high so a held start is not an edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            len_q        <= {(REF_ADDR_W+1){1'b0}};
            qdata_q      <= {QUERY_W{1'b0}};
            qlast_q      <= 1'b0;
            qcnt_q       <= 16'd0;
            done_q       <= 1'b0;
            lenerr_q     <= 1'b0;
            score_q      <= {SCORE_W{1'b0}};
            pos_q        <= {REF_ADDR_W{1'b0}};
            sr_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= dtw_cr[CR_START];
            len_q        <= len_d;
            qdata_q      <= qdata_d;
            qlast_q      <= qlast_d;
            qcnt_q       <= qcnt_d;
            done_q       <= done_d;
            lenerr_q     <= lenerr_d;
            score_q      <= score_d;
            pos_q        <= pos_d;
            sr_q         <= sr_d;
        end
    end

    dtw_sweep_ctr #(
        .REF_ADDR_W (REF_ADDR_W)
    ) u_sweep (
        .clk_i          (ACLK),
        .rst_i          (ARESET),
        .abort_i        (srst_s),
        .row_start_i    (row_start_s),
        .sweep_i        (sweep_s),
        .last_row_i     (qlast_q),
        .len_i          (len_q),
        .ref_en_o       (ref_en),
        .ref_addr_o     (ref_addr),
        .row_end_o      (row_end_s),
        .pe_valid_o     (pe_valid),
        .pe_first_col_o (pe_first_col),
        .pe_last_col_o  (pe_last_col),
        .pe_last_row_o  (pe_last_row)
    );

    assign s_query.s_query_tready = tready_s;
    assign pe_query               = qdata_q;
    assign pe_ref                 = ref_data;
    assign dtw_sr                 = sr_q;
    assign dtw_score              = score_q;
    assign dtw_pos                = pos_q;

endmodule

// File: tb/tb_dtw_core_seq.sv
// Directed bench for dtw_core_seq: hand-computed expectations for normal runs,
// length errors, start edge handling, soft-reset abort and minimum/maximum length.
module tb_dtw_core_seq;
    import dtw_pkg::*;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] dtw_cr;
    logic [31:0] dtw_ref_len;
    logic [31:0] dtw_sr;
    logic        ref_en;
    logic [14:0] ref_addr;
    logic [15:0] ref_data;
    logic        pe_valid;
    logic [15:0] pe_query;
    logic [15:0] pe_ref;
    logic        pe_first_col;
    logic        pe_last_col;
    logic        pe_last_row;
    logic        pe_res_valid;
    logic [31:0] pe_res_score;
    logic [14:0] pe_res_pos;
    logic [31:0] dtw_score;
    logic [14:0] dtw_pos;

    int err_cnt = 0;
    int chk_cnt = 0;

    dtw_core_seq_if #(.QUERY_W(16)) q_if ();

    dtw_core_seq #(
        .QUERY_W    (16),
        .REF_ADDR_W (15),
        .SCORE_W    (32)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .dtw_cr       (dtw_cr),
        .dtw_ref_len  (dtw_ref_len),
        .dtw_sr       (dtw_sr),
        .s_query      (q_if),
        .ref_en       (ref_en),
        .ref_addr     (ref_addr),
        .ref_data     (ref_data),
        .pe_valid     (pe_valid),
        .pe_query     (pe_query),
        .pe_ref       (pe_ref),
        .pe_first_col (pe_first_col),
        .pe_last_col  (pe_last_col),
        .pe_last_row  (pe_last_row),
        .pe_res_valid (pe_res_valid),
        .pe_res_score (pe_res_score),
        .pe_res_pos   (pe_res_pos),
        .dtw_score    (dtw_score),
        .dtw_pos      (dtw_pos)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    function automatic logic [15:0] ref_val(input logic [14:0] a);
        return {1'b0, a} ^ 16'h3C5A;
    endfunction

    // Reference RAM with one cycle of read latency.
    always @(posedge ACLK) begin
        if (ref_en) ref_data <= ref_val(ref_addr);
    end

    int          cyc = 0;
    int          ref_en_cnt = 0;
    int          hs_cnt = 0;
    logic [14:0] addr_log[$];
    int          ref_cyc[$];
    logic [15:0] b_ref[$];
    logic [15:0] b_query[$];
    logic [2:0]  b_flags[$];

    // Passive monitor of the values present in each clock cycle.
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (ref_en) begin
            ref_en_cnt <= ref_en_cnt + 1;
            addr_log.push_back(ref_addr);
            ref_cyc.push_back(cyc);
        end
        if (pe_valid) begin
            b_ref.push_back(pe_ref);
            b_query.push_back(pe_query);
            b_flags.push_back({pe_first_col, pe_last_col, pe_last_row});
        end
        if (q_if.s_query_tvalid && q_if.s_query_tready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_run(input logic [31:0] len);
        dtw_cr = 32'h0;
        tick();
        dtw_ref_len = len;
        dtw_cr = 32'h1;
        tick();
    endtask

    task automatic send_q(input logic [15:0] data, input logic last, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) tick();
        q_if.s_query_tdata  = data;
        q_if.s_query_tlast  = last;
        q_if.s_query_tvalid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (q_if.s_query_tready) ok = 1'b1;
            tick();
        end
        q_if.s_query_tvalid = 1'b0;
        q_if.s_query_tlast  = 1'b0;
        if (!ok) check_val("hs_timeout", 64'(0), 64'(1));
    endtask

    task automatic post_result(input logic [31:0] s, input logic [14:0] p);
        pe_res_score = s;
        pe_res_pos   = p;
        pe_res_valid = 1'b1;
        tick();
        pe_res_valid = 1'b0;
        tick();
    endtask

    int b0, bb, hs0, nb;

    initial begin
        ARESET = 1'b1;
        dtw_cr = 32'h1;
        dtw_ref_len = 32'd0;
        q_if.s_query_tdata = 16'd0;
        q_if.s_query_tvalid = 1'b0;
        q_if.s_query_tlast = 1'b0;
        pe_res_valid = 1'b0;
        pe_res_score = 32'd0;
        pe_res_pos = 15'd0;
        repeat (3) tick();
        ARESET = 1'b0;
        tick();
        tick();

        // Reset state; start held high through reset is not an edge.
        check_val("rst_sr", 64'(dtw_sr), 64'(0));
        check_val("rst_tready", 64'(q_if.s_query_tready), 64'(0));
        check_val("rst_ref_en", 64'(ref_en), 64'(0));
        check_val("rst_pe_valid", 64'(pe_valid), 64'(0));
        check_val("rst_score", 64'(dtw_score), 64'(0));
        check_val("rst_pos", 64'(dtw_pos), 64'(0));

        // Normal run: len 4, samples 10/20/30.
        b0 = ref_en_cnt;
        bb = b_ref.size();
        start_run(32'd4);
        check_val("start_tready", 64'(q_if.s_query_tready), 64'(1));
        send_q(16'd10, 1'b0, 0);
        check_val("hs_ref_en", 64'(ref_en), 64'(1));
        check_val("hs_pe_valid_n1", 64'(pe_valid), 64'(0));
        check_val("hs_addr0", 64'(ref_addr), 64'(0));
        tick();
        check_val("hs_pe_valid_n2", 64'(pe_valid), 64'(1));
        send_q(16'd20, 1'b0, 0);
        send_q(16'd30, 1'b1, 0);
        repeat (6) tick();
        check_val("norm_ref_cnt", 64'(ref_en_cnt - b0), 64'(12));
        check_val("norm_beats", 64'(b_ref.size() - bb), 64'(12));
        if (addr_log.size() >= b0 + 12 && b_ref.size() >= bb + 12) begin
            for (int i = 0; i < 12; i++) begin
                check_val($sformatf("norm_addr%0d", i), 64'(addr_log[b0+i]), 64'(i % 4));
                check_val($sformatf("norm_ref%0d", i), 64'(b_ref[bb+i]), 64'(ref_val(15'(i % 4))));
                check_val($sformatf("norm_flags%0d", i), 64'(b_flags[bb+i]),
                          64'({(i % 4) == 0, (i % 4) == 3, i >= 8}));
                check_val($sformatf("norm_query%0d", i), 64'(b_query[bb+i]), 64'((i / 4 + 1) * 10));
            end
            check_val("norm_span", 64'(ref_cyc[b0+11] - ref_cyc[b0]), 64'(13));
        end
        check_val("norm_sr_busy", 64'(dtw_sr), 64'(32'h0003_0001));
        post_result(32'h1234, 15'd2);
        check_val("norm_sr_done", 64'(dtw_sr), 64'(32'h0003_0002));
        check_val("norm_score", 64'(dtw_score), 64'(32'h1234));
        check_val("norm_pos", 64'(dtw_pos), 64'(2));
        post_result(32'hBEEF, 15'd7);
        check_val("res_ignored_score", 64'(dtw_score), 64'(32'h1234));
        check_val("res_ignored_pos", 64'(dtw_pos), 64'(2));

        // Length errors: zero and one past maximum.
        b0 = ref_en_cnt;
        start_run(32'd0);
        tick();
        check_val("len0_sr", 64'(dtw_sr), 64'(32'h6));
        check_val("len0_score_clr", 64'(dtw_score), 64'(0));
        start_run(32'd32769);
        tick();
        check_val("len32769_sr", 64'(dtw_sr), 64'(32'h6));
        repeat (3) tick();
        check_val("lenerr_no_ref_en", 64'(ref_en_cnt - b0), 64'(0));

        // Maximum length: full row without early wrap.
        b0 = ref_en_cnt;
        bb = b_ref.size();
        start_run(32'd32768);
        check_val("max_tready", 64'(q_if.s_query_tready), 64'(1));
        send_q(16'h0007, 1'b1, 0);
        for (int i = 0; i < 33000 && (ref_en_cnt - b0) < 32768; i++) tick();
        repeat (4) tick();
        check_val("max_ref_cnt", 64'(ref_en_cnt - b0), 64'(32768));
        check_val("max_beats", 64'(b_ref.size() - bb), 64'(32768));
        if (addr_log.size() >= b0 + 32768 && b_flags.size() >= bb + 32768) begin
            check_val("max_addr_first", 64'(addr_log[b0]), 64'(0));
            check_val("max_addr_last", 64'(addr_log[b0+32767]), 64'(15'h7FFF));
            check_val("max_flags_first", 64'(b_flags[bb]), 64'(3'b101));
            check_val("max_flags_last", 64'(b_flags[bb+32767]), 64'(3'b011));
        end
        post_result(32'h55, 15'h7FFF);
        check_val("max_pos", 64'(dtw_pos), 64'(15'h7FFF));

        // Start level held ~20 cycles: one start; a second edge while busy is ignored.
        dtw_cr = 32'h0;
        tick();
        dtw_ref_len = 32'd4;
        dtw_cr = 32'h1;
        tick();
        send_q(16'd5, 1'b0, 0);
        repeat (12) tick();
        check_val("held_one_start", 64'(dtw_sr), 64'(32'h0001_0001));
        dtw_cr = 32'h0;
        tick();
        tick();
        dtw_cr = 32'h1;
        tick();
        tick();
        check_val("busy_edge_ignored", 64'(dtw_sr), 64'(32'h0001_0001));
        send_q(16'd6, 1'b1, 0);
        repeat (6) tick();
        check_val("held_sr_2", 64'(dtw_sr), 64'(32'h0002_0001));
        post_result(32'h9, 15'd1);
        check_val("held_sr_done", 64'(dtw_sr), 64'(32'h0002_0002));

        // Soft reset at column 5 of a default-length sweep.
        start_run(DEF_REF_LEN);
        send_q(16'd1, 1'b0, 0);
        for (int i = 0; i < 20 && ref_addr != 15'd5; i++) tick();
        check_val("srst_at_col5", 64'(ref_addr), 64'(5));
        dtw_cr = 32'h2;
        tick();
        nb = b_ref.size();
        check_val("srst_ref_en", 64'(ref_en), 64'(0));
        check_val("srst_pe_valid", 64'(pe_valid), 64'(0));
        check_val("srst_tready", 64'(q_if.s_query_tready), 64'(0));
        check_val("srst_sr", 64'(dtw_sr), 64'(0));
        tick();
        tick();
        dtw_cr = 32'h0;
        tick();
        tick();
        check_val("srst_no_late_beat", 64'(b_ref.size() - nb), 64'(0));
        check_val("srst_sr_idle", 64'(dtw_sr), 64'(0));

        // Minimum length with tvalid gaps.
        bb = b_ref.size();
        hs0 = hs_cnt;
        start_run(32'd1);
        send_q(16'd100, 1'b0, 3);
        send_q(16'd200, 1'b0, 3);
        send_q(16'd300, 1'b1, 3);
        repeat (5) tick();
        check_val("min_beats", 64'(b_ref.size() - bb), 64'(3));
        check_val("min_beats_vs_hs", 64'(b_ref.size() - bb), 64'(hs_cnt - hs0));
        if (b_flags.size() >= bb + 3) begin
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("min_flags%0d", i), 64'(b_flags[bb+i]), 64'({1'b1, 1'b1, i == 2}));
                check_val($sformatf("min_query%0d", i), 64'(b_query[bb+i]), 64'((i + 1) * 100));
                check_val($sformatf("min_ref%0d", i), 64'(b_ref[bb+i]), 64'(ref_val(15'd0)));
            end
        end
        post_result(32'h77, 15'd0);
        check_val("min_sr_done", 64'(dtw_sr), 64'(32'h0003_0002));
        check_val("min_score", 64'(dtw_score), 64'(32'h77));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dtw_core_seq.md
# dtw_core_seq

Control sequencer for the DTW core, directly downstream of the AXI-Lite register slave. It decodes the control register word (`dtw_cr`) and reference length (`dtw_ref_len`) and accepts query samples over an AXI-Stream-style handshake. For each query sample it sweeps the reference memory and drives the processing-element (PE) pipeline with aligned operand pairs. It captures the final score and position, and returns the status word (`dtw_sr`) to the register slave.

## Interface
- `QUERY_W`, 16: query/reference sample width.
- `REF_ADDR_W`, 15: reference address width. Maximum reference length is 2^REF_ADDR_W = 32768.
- `SCORE_W`, 32: score width.
- `ACLK`, in, 1: single clock.
- `ARESET`, in, 1: synchronous, active-high reset.
- `dtw_cr`, in, 32: control word. Bit 0 is start (level, edge-detected here). Bit 1 is soft reset (level). Bits 31:2 are ignored.
- `dtw_ref_len`, in, 32: reference length in samples. Sampled only on an accepted start.
- `dtw_sr`, out, 32: status word.
  - bit 0: busy.
  - bit 1: done, sticky.
  - bit 2: len_err, sticky.
  - bits 15:3: zero.
  - bits 31:16: query samples consumed, saturating at 16'hFFFF.
- `s_query_tdata`, in, QUERY_W: query sample.
- `s_query_tvalid`, in, 1.
- `s_query_tready`, out, 1.
- `s_query_tlast`, in, 1: marks the final query sample.
- `ref_en`, out, 1: reference RAM read enable.
- `ref_addr`, out, REF_ADDR_W: reference RAM address.
- `ref_data`, in, QUERY_W: reference RAM read data, valid exactly 1 cycle after `ref_en`.
- `pe_valid`, out, 1: operand pair valid. The PE accepts every cycle; there is no backpressure.
- `pe_query`, out, QUERY_W: current query sample.
- `pe_ref`, out, QUERY_W: equals `ref_data`.
- `pe_first_col`, out, 1: first column of a row.
- `pe_last_col`, out, 1: last column of a row.
- `pe_last_row`, out, 1: row belongs to the tlast sample.
- `pe_res_valid`, in, 1: final result strobe from the PE.
- `pe_res_score`, in, SCORE_W.
- `pe_res_pos`, in, REF_ADDR_W.
- `dtw_score`, out, SCORE_W: captured result, held until the next accepted start.
- `dtw_pos`, out, REF_ADDR_W: captured result position, held until the next accepted start.

## Operation
- **States:** IDLE, WAIT_Q, SWEEP, WAIT_RES, DONE.
- **Start:** a start is a 0→1 transition of `dtw_cr[0]`, compared against its registered previous value. It is accepted only in IDLE or DONE.
  - On an accepted start: clear done, len_err, the query count, `dtw_score` and `dtw_pos`.
  - Latch `len = dtw_ref_len`.
  - If `len == 0` or `len > 2^REF_ADDR_W`: set len_err and done, go to DONE, and perform no sweep.
  - Otherwise go to WAIT_Q.
- **WAIT_Q:** `s_query_tready = 1`. On handshake, latch the sample and the last flag, increment the query count, go to SWEEP with column counter `col = 0`.
- **SWEEP:**
  - Each cycle, `ref_en = 1` and `ref_addr = col`, then `col` increments.
  - At `col == len-1`: if the last flag is set, go to WAIT_RES; otherwise go to WAIT_Q.
- **PE issue:** stage-1 registers delay `ref_en`, first (`col == 0`), last (`col == len-1`) and last_row by one cycle. They drive `pe_valid`, `pe_first_col`, `pe_last_col` and `pe_last_row`, aligned with `ref_data`. `pe_query` is held stable for the whole row.
- **WAIT_RES:** on `pe_res_valid`, capture score and position, set done, go to DONE. A `pe_res_valid` in any other state is ignored.
- **DONE:** behaves as IDLE with done set. A start re-arms the block.
- **Soft reset:** while `dtw_cr[1]` is high, the FSM goes to IDLE, flags and counters clear, and outputs take their reset values. It has priority over start.
- **Busy:** `busy = 1` in WAIT_Q, SWEEP and WAIT_RES.

## Timing
- **Reset values:** all outputs are 0 and the FSM is in IDLE. The registered previous value of `dtw_cr[0]` resets to 1, so a start held high through reset is not taken as an edge.
- **Start to tready:** a start edge at cycle N gives `s_query_tready` high at N+1.
- **Handshake to operands:** a handshake at cycle N gives `ref_en` at N+1 and `pe_valid` at N+2.
- **Row length and throughput:**
  - A row is exactly `len` consecutive `ref_en` cycles.
  - The next `tready` is asserted the cycle after the last address.
  - Minimum per-sample period is `len+1` cycles.
- **Result to status:** `pe_res_valid` at cycle N gives done visible in `dtw_sr` at N+1.
- **`dtw_sr`:** registered, 1-cycle latency from internal state.
- **Abort mid-sweep:** soft reset or `ARESET` during SWEEP drops `ref_en` the next cycle. The already-issued stage-1 `pe_valid` is also cleared, so no partial beat appears after the abort cycle.
- **Edge cases:**
  - Start during busy is ignored, but the edge detector still updates.
  - `len = 1`: `pe_first_col` and `pe_last_col` are asserted on the same beat.
  - `len = 2^REF_ADDR_W`: `col` counts to all-ones without wrapping early. The counter is REF_ADDR_W+1 bits wide.

## Structure
- Package `dtw_pkg`:
  - State enum.
  - CR bit indices `CR_START = 0`, `CR_SRST = 1`.
  - SR bit indices `SR_BUSY = 0`, `SR_DONE = 1`, `SR_LENERR = 2`, `SR_QCNT_LSB = 16`.
  - `DEF_REF_LEN = 29898`.
- One natural sub-module: `dtw_sweep_ctr`, the column counter plus first/last flag generation and its stage-1 alignment registers. The FSM and status logic stay in the top level.

## Test plan
- **Normal run:** `len = 4`, three query samples 10/20/30 with tlast on 30.
  - `ref_addr` takes 0,1,2,3 three times.
  - `pe_valid` shows 12 beats.
  - first/last flags are set on beats 0 and 3 of each row; `pe_last_row` only in row 3.
  - `sr[31:16] = 3`.
  - `pe_res_valid` with score 0x1234 and position 2 gives `dtw_score = 0x1234`, `dtw_pos = 2`, `sr = 0x0003_0002`.
- **Length error:** `len = 0` → `sr[2:0] = 3'b110` two cycles after the start edge, with no `ref_en`.
- **Length error:** `len = 32769` → same `sr[2:0] = 3'b110` two cycles after the start edge, with no `ref_en`.
- **Start level held:** hold `dtw_cr[0]` high for 20 cycles → exactly one start. A second edge while busy → no restart.
- **Soft reset mid-sweep:** `dtw_cr[1]` at column 5 of `len = 29898` → `ref_en` and `pe_valid` are 0 from the next cycle, `sr = 0`, `tready = 0`.
- **Minimum length with tvalid gaps:** `len = 1`, tvalid gaps between samples → each `pe_valid` beat has both first and last set, and no beat occurs without a prior handshake.
